tcam_master: RTL
================

TCAM_MASTER -- requirements
Module: tcam_master

Interface
REQ-001 Parameter DEPTH, 10: number of TCAM entries driven.
REQ-002 Parameter WIDTH, 17: TCAM word width.
REQ-003 Parameter AW, 4: address width; DEPTH <= 2**AW.
REQ-004 Parameter SEARCH_LAT, 1: TCAM search latency in cycles, >= 1.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_op  input  2  operation: 00 WRITE, 01 SEARCH, 10 FILL, 11 reserved.
REQ-010 cmd_addr  input  AW  write address; ignored for SEARCH and FILL.
REQ-011 cmd_data  input  WIDTH  write word or search key.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_err  output  1  1 = command rejected.
REQ-015 rsp_found  output  1  search hit flag; 0 for non-search.
REQ-016 rsp_addr  output  AW  hit address (SEARCH), written address (WRITE), DEPTH-1 (FILL).
REQ-017 rsp_data  output  WIDTH  matched TCAM entry (SEARCH), else echoed cmd_data.
REQ-018 tcam_we, tcam_waddr[AW], tcam_data[WIDTH], tcam_search  outputs: TCAM write/search port.
REQ-019 tcam_saddr[AW], tcam_sdata[WIDTH], tcam_found  inputs: TCAM search result.

Function
REQ-020 FSM states: IDLE, WRITE, FILL, SEARCH, RESP; cmd_ready = 1 only in IDLE.
REQ-021 All outputs SHALL be registered; tcam_we and tcam_search = 0 outside WRITE/FILL and SEARCH respectively.
REQ-022 Accept in IDLE: latch op/addr/data; WRITE with cmd_addr < DEPTH -> WRITE; SEARCH -> SEARCH; FILL -> FILL.
REQ-023 WRITE with cmd_addr >= DEPTH, or op 11: no TCAM access, go directly to RESP with rsp_err = 1.
REQ-024 WRITE: exactly one cycle with tcam_we = 1, tcam_waddr = latched addr, tcam_data = latched data; then RESP.
REQ-025 FILL: DEPTH consecutive cycles with tcam_we = 1, tcam_waddr counting 0..DEPTH-1, tcam_data = latched data; then RESP.
REQ-026 SEARCH: tcam_search = 1 and tcam_data = key held for SEARCH_LAT+1 cycles; tcam_found/saddr/sdata sampled at the end of the last cycle; then RESP.
REQ-027 Search miss: rsp_found = 0, rsp_addr = 0, rsp_data = 0.
REQ-028 RESP: rsp_valid = 1, fields stable until rsp_ready; on handshake return to IDLE, cmd_ready = 1 next cycle.
REQ-029 Latency from accept edge to rsp_valid: WRITE 2 cycles, FILL DEPTH+1, SEARCH SEARCH_LAT+2, error 1.
REQ-030 cmd_valid while busy SHALL be ignored (not accepted, no side effect); one command in flight maximum.
REQ-031 rsp_ready held low SHALL stall indefinitely in RESP with no TCAM activity.

Reset
REQ-032 rst SHALL, at the next edge, force IDLE and set rsp_valid, rsp_err, rsp_found, tcam_we, tcam_search = 0, all address/data outputs = 0, cmd_ready = 1 the cycle after.
REQ-033 rst mid-FILL SHALL abort the fill (already-written entries remain), and mid-RESP SHALL drop the pending response.

Structure
REQ-034 Shared package tcam_pkg SHALL hold op encodings (OP_WRITE, OP_SEARCH, OP_FILL), the FSM state type and default DEPTH/WIDTH constants.
REQ-035 Single module, no sub-modules; the TCAM itself is instantiated only in the bench.

Verification (DEPTH 10, WIDTH 17, SEARCH_LAT 1, tcam instance attached)
REQ-036 WRITE addr 1 data 17'b11111100100000000 -> one tcam_we pulse at waddr 1, rsp_valid 2 cycles after accept, rsp_err 0, rsp_addr 1.
REQ-037 Then SEARCH 17'b11111100100000000 -> tcam_search high 2 cycles, rsp_found 1, rsp_addr 1, rsp_data = that word, 3 cycles after accept.
REQ-038 SEARCH 17'b01010101010101010 with no matching entry -> rsp_found 0, rsp_addr 0, rsp_data 0, rsp_err 0.
REQ-039 WRITE addr 12 and op 11 -> no tcam_we, rsp_err 1 one cycle after accept.
REQ-040 FILL 17'b0 with rsp_ready low 5 cycles -> waddr 0..9 on consecutive cycles, rsp held stable, cmd_ready 0 until handshake; rst at FILL cycle 4 -> entries 0..3 written, IDLE, rsp_valid 0.

Source files
------------

// File: rtl/tcam_pkg.sv
// tcam_pkg: op encodings, FSM state type and default geometry shared by tcam_master and its users
package tcam_pkg;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam int DEF_DEPTH = 10;
  localparam int DEF_WIDTH = 17;
  typedef enum logic [2:0] {IDLE, WRITE, FILL, SEARCH, RESP} state_t;
endpackage

// File: rtl/tcam_master.sv
// tcam_master: one-at-a-time command engine (cmd_* in, rsp_* out) driving a TCAM write/search port (tcam_* out, tcam_s*/tcam_found in)
module tcam_master
  import tcam_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int AW         = 4,
  parameter int SEARCH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic             rsp_found,
  output logic [AW-1:0]    rsp_addr,
  output logic [WIDTH-1:0] rsp_data,
  output logic             tcam_we,
  output logic [AW-1:0]    tcam_waddr,
  output logic [WIDTH-1:0] tcam_data,
  output logic             tcam_search,
  input  logic [AW-1:0]    tcam_saddr,
  input  logic [WIDTH-1:0] tcam_sdata,
  input  logic             tcam_found
);
  state_t state;
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_found   <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      tcam_we     <= 1'b0;
      tcam_waddr  <= '0;
      tcam_data   <= '0;
      tcam_search <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          cnt       <= '0;
          tcam_data <= cmd_data;
          if (cmd_op == OP_WRITE && int'(cmd_addr) < DEPTH) begin
            state      <= WRITE;
            tcam_we    <= 1'b1;
            tcam_waddr <= cmd_addr;
          end else if (cmd_op == OP_SEARCH) begin
            state       <= SEARCH;
            tcam_search <= 1'b1;
          end else if (cmd_op == OP_FILL) begin
            state      <= FILL;
            tcam_we    <= 1'b1;
            tcam_waddr <= '0;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_found <= 1'b0;
            rsp_addr  <= cmd_addr;
            rsp_data  <= cmd_data;
          end
        end
        WRITE: begin
          state     <= RESP;
          tcam_we   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_found <= 1'b0;
          rsp_addr  <= tcam_waddr;
          rsp_data  <= tcam_data;
        end
        FILL: if (tcam_waddr == AW'(DEPTH - 1)) begin
          state     <= RESP;
          tcam_we   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_found <= 1'b0;
          rsp_addr  <= AW'(DEPTH - 1);
          rsp_data  <= tcam_data;
        end else begin
          tcam_waddr <= tcam_waddr + 1'b1;
        end
        // the key is held SEARCH_LAT+1 cycles so the TCAM result is valid on the last one
        SEARCH: if (cnt == 16'(SEARCH_LAT)) begin
          state       <= RESP;
          tcam_search <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_err     <= 1'b0;
          rsp_found   <= tcam_found;
          rsp_addr    <= tcam_found ? tcam_saddr : '0;
          rsp_data    <= tcam_found ? tcam_sdata : '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
